// File: rtl/gray_sync_pkg.sv
// Shared constants and helpers for the gray-code receive stage.
package gray_sync_pkg;

  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned WIDTH_MAX       = 32;

  // Zero-extended input decodes correctly: leading zero gray bits stay zero in binary.
  function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] g);
    logic [WIDTH_MAX-1:0] b;
    b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
    for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [WIDTH_MAX-1:0] x);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH_MAX; i++) begin
      cnt = cnt + 6'(x[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_sync_decode4_chain.sv
// Multi-flop synchronizer for a gray-coded word; no logic ahead of the first stage.
module gray_sync_chain
  import gray_sync_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             CDN,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("gray_sync_chain: SYNC_STAGES must be 2..%0d", SYNC_STAGES_MAX);
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_s;

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      r_s <= '0;
    end else begin
      r_s <= {r_s[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_s[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decode4.sv
// Receive-side gray counter stage: synchronize, decode to binary, report step size and
// flag multi-bit transitions with a sticky error.
module gray_sync_decode4
  import gray_sync_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             CDN,
  input  logic [WIDTH-1:0] G,
  input  logic             MASK,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] Q,
  output logic             CHG,
  output logic [WIDTH-1:0] DIFF,
  output logic             ERR
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("gray_sync_decode4: WIDTH must be 1..%0d", WIDTH_MAX);
  end

  logic [WIDTH-1:0] w_g_s;
  logic [WIDTH-1:0] w_bin;
  logic [5:0]       w_hd;
  logic             w_upd;
  logic             w_multi;
  logic [WIDTH-1:0] w_q_d;
  logic [WIDTH-1:0] w_diff_d;
  logic             w_err_d;

  logic [WIDTH-1:0] r_g_prev;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_diff;
  logic             r_chg;
  logic             r_err;

  gray_sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_chain (
    .CLK (CLK),
    .CDN (CDN),
    .i_d (G),
    .o_q (w_g_s)
  );

  always_comb begin
    w_hd     = popcount(WIDTH_MAX'(w_g_s ^ r_g_prev));
    w_bin    = WIDTH'(gray2bin(WIDTH_MAX'(w_g_s)));
    w_upd    = (w_hd != 6'd0);
    w_multi  = (w_hd > 6'd1);
    w_q_d    = r_q;
    w_diff_d = r_diff;
    if (w_upd) begin
      w_q_d    = w_bin;
      w_diff_d = w_bin - r_q;
    end
    // A fresh error on the same edge outranks a clear request.
    w_err_d = r_err;
    if (w_multi && !MASK) begin
      w_err_d = 1'b1;
    end else if (ERR_CLR) begin
      w_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      r_g_prev <= '0;
      r_q      <= '0;
      r_diff   <= '0;
      r_chg    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_g_prev <= w_g_s;
      r_q      <= w_q_d;
      r_diff   <= w_diff_d;
      r_chg    <= w_upd;
      r_err    <= w_err_d;
    end
  end

  assign Q    = r_q;
  assign DIFF = r_diff;
  assign CHG  = r_chg;
  assign ERR  = r_err;

endmodule
